// File: rtl/shape_proc_arbiter_pkg.sv
// Shared types and helpers for the shape processor arbiter.
//   state_e           : transaction FSM states
//   SHAPE_*/OP_*      : bit positions of the checked register fields
//   KEEP_SHAPE/KEEP_OP: field values meaning "leave unchanged", never checked
//   is_write_rejected : readback comparison used for the reject verdict
package shape_proc_arbiter_pkg;

  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_e;

  localparam int SHAPE_MSB = 17;
  localparam int SHAPE_LSB = 16;
  localparam int OP_MSB    = 5;
  localparam int OP_LSB    = 0;

  localparam logic [1:0] KEEP_SHAPE = 2'b11;
  localparam logic [5:0] KEEP_OP    = 6'h3F;

  // Only the shape and operation fields are compared; any other bit may differ.
  function automatic logic is_write_rejected(input logic [31:0] req, input logic [31:0] readback);
    logic shape_bad;
    logic op_bad;
    shape_bad = (req[SHAPE_MSB:SHAPE_LSB] != KEEP_SHAPE) &&
                (req[SHAPE_MSB:SHAPE_LSB] != readback[SHAPE_MSB:SHAPE_LSB]);
    op_bad    = (req[OP_MSB:OP_LSB] != KEEP_OP) &&
                (req[OP_MSB:OP_LSB] != readback[OP_MSB:OP_LSB]);
    return shape_bad | op_bad;
  endfunction

endpackage

// File: rtl/shape_proc_arbiter_rr.sv
// shape_rr_arbiter: round-robin next-grant select plus pointer register.
//   clk, rst_n   : clock, async active-low reset
//   req_valid_i  : per-requester pending requests
//   ptr_en_i     : load the pointer with the current grant
//   any_o        : at least one request pending
//   grant_idx_o  : index of the first valid requester after the pointer
//   grant_oh_o   : one-hot form of grant_idx_o (zero when nothing pending)
module shape_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic               ptr_en_i,
  output logic               any_o,
  output logic [IW-1:0]      grant_idx_o,
  output logic [NUM_REQ-1:0] grant_oh_o
);

  logic [IW-1:0] ptr_q;

  // Scan from farthest to nearest so the requester closest after the
  // pointer is the last assignment and therefore wins.
  always_comb begin
    int cand;
    any_o       = |req_valid_i;
    grant_idx_o = ptr_q;
    cand        = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (req_valid_i[cand]) grant_idx_o = IW'(cand);
    end
    grant_oh_o = any_o ? (NUM_REQ'(1) << grant_idx_o) : '0;
  end

  // Reset to the last requester so requester 0 is favoured first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr_q <= IW'(NUM_REQ - 1);
    else if (ptr_en_i) ptr_q <= grant_idx_o;
  end

endmodule

// File: rtl/shape_proc_arbiter.sv
// shape_proc_arbiter: shares the shape processor write/read port between
// NUM_REQ requesters. Each write is followed by a readback; reads only do
// the readback. The owner receives the readback and a reject verdict.
//   req_valid/req_ready/req_write/req_data : request side, one slot per requester
//   resp_valid/resp_ready                  : per-requester response handshake
//   resp_data/resp_rejected                : shared response payload
//   sp_write/sp_write_data/sp_read/sp_read_data : shape processor port
// Optional: SHAPE_PROC_ARBITER_STATS_EN adds stat_reject_count, one 16-bit
// saturating reject counter per requester.
module shape_proc_arbiter
  import shape_proc_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_rejected,
  output logic                  sp_write,
  output logic [31:0]           sp_write_data,
  output logic                  sp_read,
  input  logic [31:0]           sp_read_data
`ifdef SHAPE_PROC_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_reject_count
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW = $clog2(READ_LATENCY) + 1;

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] g_q;
  logic          wr_q;
  logic [31:0]   data_q;
  logic [31:0]   resp_data_q;
  logic          rej_q;

  logic               any;
  logic [IW-1:0]      gidx;
  logic [NUM_REQ-1:0] goh;
  logic               grant_fire;
  logic               cap;
  logic               hs;

  shape_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .ptr_en_i    (grant_fire),
    .any_o       (any),
    .grant_idx_o (gidx),
    .grant_oh_o  (goh)
  );

  // Strobes decode straight from state_q so they drop with the async reset.
  // Grants are also masked by rst_n so nothing is accepted while held in reset.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    grant_fire    = 1'b0;
    cap           = 1'b0;
    hs            = 1'b0;
    req_ready     = '0;
    resp_valid    = '0;
    sp_write      = 1'b0;
    sp_write_data = '0;
    sp_read       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any && rst_n) begin
          grant_fire = 1'b1;
          req_ready  = goh;
          state_d    = req_write[gidx] ? WR : RD;
        end
      end
      WR: begin
        sp_write      = 1'b1;
        sp_write_data = data_q;
        state_d       = RD;
      end
      RD: begin
        sp_read = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Readback is valid READ_LATENCY cycles after RD, i.e. at WAIT count LATENCY-1.
        if (cnt_q == LW'(READ_LATENCY - 1)) begin
          cap     = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        resp_valid = NUM_REQ'(1) << g_q;
        if (resp_ready[g_q]) begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      g_q         <= '0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      resp_data_q <= '0;
      rej_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant_fire) begin
        g_q    <= gidx;
        wr_q   <= req_write[gidx];
        data_q <= req_data[32*gidx +: 32];
      end
      if (cap) begin
        resp_data_q <= sp_read_data;
        rej_q       <= wr_q && is_write_rejected(data_q, sp_read_data);
      end
    end
  end

  assign resp_data     = resp_data_q;
  assign resp_rejected = rej_q;

`ifdef SHAPE_PROC_ARBITER_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [15:0] cnt_stat_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_stat_q <= '0;
      else if (hs && rej_q && (g_q == IW'(i)) && (cnt_stat_q != 16'hFFFF))
        cnt_stat_q <= cnt_stat_q + 16'd1;
    end
    assign stat_reject_count[16*i +: 16] = cnt_stat_q;
  end
`endif

endmodule

// File: tb/tb_shape_proc_arbiter.sv
// Scoreboard bench for shape_proc_arbiter (NUM_REQ=2, READ_LATENCY=3).
// Stimulus pushes the expected transaction when it issues a request; a
// negedge monitor pops it at grant and checks strobes, latency and response.
// The readback model drives the true value only in the cycle exactly
// READ_LATENCY after sp_read, and the inverse otherwise.
module tb_shape_proc_arbiter;

  localparam int NR = 2;
  localparam int RL = 3;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] data;
    logic [31:0] rb;
    bit          rej;
  } txn_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NR-1:0]        req_valid = '0;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        req_write = '0;
  logic [NR-1:0][31:0]  req_data = '0;
  logic [NR-1:0]        resp_valid;
  logic [NR-1:0]        resp_ready = '0;
  logic [31:0]          resp_data;
  logic                 resp_rejected;
  logic                 sp_write;
  logic [31:0]          sp_write_data;
  logic                 sp_read;
  logic [31:0]          sp_read_data;

  logic [31:0]   rb_val = '0;
  logic [RL-1:0] rd_sh;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  txn_t          exp_q[$];

  shape_proc_arbiter #(.NUM_REQ(NR), .READ_LATENCY(RL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_data      (req_data),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_rejected (resp_rejected),
    .sp_write      (sp_write),
    .sp_write_data (sp_write_data),
    .sp_read       (sp_read),
    .sp_read_data  (sp_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_sh <= '0;
    else        rd_sh <= {rd_sh[RL-2:0], sp_read};
  assign sp_read_data = rd_sh[RL-1] ? rb_val : ~rb_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  txn_t cur;
  bit   pending = 0;
  bit   first = 0;
  int   g_cyc = 0;
  int   nwr = 0;
  int   nrd = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
    end else begin
      if (req_ready != '0) begin
        chk("prev_txn_done", 32'(pending), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(req_ready), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("grant", 32'(req_ready), 32'd1 << cur.idx);
          g_cyc = cyc; pending = 1; first = 1; nwr = 0; nrd = 0;
        end
      end
      if (sp_write) begin
        if (!pending) chk("stale_sp_write", 32'(sp_write), 32'd0);
        else begin
          chk("wr_data", sp_write_data, cur.data);
          chk("wr_cycle", 32'(cyc - g_cyc), 32'd1);
          nwr++;
        end
      end
      if (sp_read) begin
        if (!pending) chk("stale_sp_read", 32'(sp_read), 32'd0);
        else begin
          chk("rd_cycle", 32'(cyc - g_cyc), cur.wr ? 32'd2 : 32'd1);
          nrd++;
        end
      end
      if (resp_valid != '0) begin
        if (!pending) chk("stale_resp", 32'(resp_valid), 32'd0);
        else begin
          chk("resp_owner", 32'(resp_valid), 32'd1 << cur.idx);
          if (first) chk("resp_latency", 32'(cyc - g_cyc), cur.wr ? 32'(3 + RL) : 32'(2 + RL));
          first = 0;
          chk("resp_data", resp_data, cur.rb);
          chk("resp_rej", 32'(resp_rejected), 32'(cur.rej));
          if (resp_ready[cur.idx]) begin
            chk("strobe_counts", 32'({nwr[7:0], nrd[7:0]}), {16'd0, cur.wr ? 8'd1 : 8'd0, 8'd1});
            pending = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input int idx, input bit wr, input logic [31:0] data,
                     input logic [31:0] rb, input bit rej, input int hold, input bit other_rdy);
    txn_t t;
    bit   got;
    t.idx = idx; t.wr = wr; t.data = data; t.rb = rb; t.rej = rej;
    exp_q.push_back(t);
    rb_val         = rb;
    req_write[idx] = wr;
    req_data[idx]  = data;
    req_valid[idx] = 1'b1;
    if (other_rdy) resp_ready[1-idx] = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      got = req_ready[idx];
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    req_data[idx]  = ~data;  // must be ignored after grant
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      got = resp_valid[idx];
    end
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
    repeat (hold + 1) @(posedge clk);
    #1 resp_ready[idx] = 1'b1;
    @(posedge clk); #1;
    resp_ready = '0;
  endtask

  initial begin
    bit got;
    #12;
    chk("rst_strobes", 32'({req_ready, resp_valid, resp_rejected, sp_write, sp_read}), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_wr_data", sp_write_data, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed writes: idx, wr, data, readback, expected reject
    txn(0, 1, 32'h0001_0010, 32'h0001_0010, 0, 0, 0);
    txn(1, 1, 32'h0002_0010, 32'h0001_0000, 1, 0, 0);
    txn(0, 1, 32'h0003_003F, 32'h1234_5678, 0, 0, 0);  // both fields keep
    txn(1, 1, 32'h0003_0012, 32'h0002_0012, 0, 0, 0);  // shape keep, op equal
    txn(0, 1, 32'h0001_003F, 32'h0002_0000, 1, 0, 0);  // op keep, shape differs
    txn(1, 1, 32'hFFFC_0005, 32'h0000_0005, 0, 0, 0);  // unchecked bits differ

    // both requesters held valid: expect 0,1,0,1
    req_write = 2'b11;
    req_data[0] = 32'h0001_0005;
    req_data[1] = 32'h0002_0005;
    rb_val = 32'h0001_0005;
    for (int k = 0; k < 4; k++) begin
      txn_t t;
      t.idx = k % 2; t.wr = 1; t.data = req_data[k%2]; t.rb = 32'h0001_0005; t.rej = (k % 2 == 1);
      exp_q.push_back(t);
    end
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        @(negedge clk);
        got = (resp_valid != '0);
      end
      if (!got) chk("rr_resp_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      resp_ready = resp_valid;
      if (k == 3) req_valid = '0;
      @(posedge clk); #1;
      resp_ready = '0;
    end

    // read, response held 5 cycles, non-owner ready ignored
    txn(0, 0, 32'hAAAA_AAAA, 32'hCAFE_F00D, 0, 5, 1);

    // reset during WAIT
    begin
      txn_t t;
      t.idx = 0; t.wr = 1; t.data = 32'h0001_0010; t.rb = 32'h0001_0010; t.rej = 0;
      exp_q.push_back(t);
    end
    rb_val = 32'h0001_0010;
    req_write[0] = 1'b1; req_data[0] = 32'h0001_0010; req_valid[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      got = req_ready[0];
    end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      got = sp_read;
    end
    if (!got) chk("rst_test_read_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_strobes", 32'({req_ready, resp_valid, resp_rejected, sp_write, sp_read}), 32'd0);
    chk("midrst_resp_data", resp_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    txn(0, 1, 32'h0001_0010, 32'h0001_0010, 0, 0, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("no_pending", 32'(pending), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
